// File: rtl/rc4_decrypt_loop_if.sv
// Bundle between the RC4 keystream/decrypt stage and its S memory, encrypted ROM,
// decrypted RAM and downstream character checker.
interface rc4_decrypt_loop_if;
    logic       start;
    logic       start_over;
    logic       compared_char;
    logic [7:0] s_addr;
    logic [7:0] s_wdata;
    logic       s_wren;
    logic [7:0] s_rdata;
    logic [4:0] rom_addr;
    logic [7:0] rom_rdata;
    logic [4:0] dec_addr;
    logic [7:0] dec_wdata;
    logic       dec_wren;
    logic [7:0] char_out;
    logic       new_char;
    logic [5:0] k;
    logic       busy;
    logic       done;

    modport slave (
        input  start, start_over, compared_char, s_rdata, rom_rdata,
        output s_addr, s_wdata, s_wren, rom_addr, dec_addr, dec_wdata, dec_wren,
        output char_out, new_char, k, busy, done
    );

    modport master (
        output start, start_over, compared_char, s_rdata, rom_rdata,
        input  s_addr, s_wdata, s_wren, rom_addr, dec_addr, dec_wdata, dec_wren,
        input  char_out, new_char, k, busy, done
    );
endinterface

// File: rtl/rc4_decrypt_loop.sv
// RC4 keystream generator over the S-box built by the earlier loops: decrypts the
// ROM one byte at a time and hands each plaintext character to the checker.
module rc4_decrypt_loop #(
    parameter int MSG_LEN = 32
) (
    input  logic               clok,
    input  logic               resetm,
    rc4_decrypt_loop_if.slave  bus
);
    localparam logic [5:0] LAST_K = 6'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, SI_ADDR, SI_WAIT, SI_LATCH, SJ_ADDR, SJ_WAIT, SJ_LATCH,
        WR_I, WR_J, F_ADDR, F_WAIT, F_LATCH, EMIT, WAIT_CMP, DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d;
    logic [7:0] si_q, si_d, sj_q, sj_d;
    logic [7:0] f_q, f_d, enc_q, enc_d;
    logic [5:0] k_q, k_d;
    logic       ack_pend_q, ack_pend_d;
    logic [7:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic       s_wren_q, s_wren_d;
    logic [4:0] rom_addr_q, rom_addr_d, dec_addr_q, dec_addr_d;
    logic       dec_wren_q, dec_wren_d, new_char_q, new_char_d;
    logic       ack_seen;
    logic [7:0] j_sum;

    // An acknowledge sampled on the edge that leaves EMIT is remembered so WAIT_CMP still honours it.
    assign ack_seen = bus.compared_char | ack_pend_q;
    assign j_sum    = j_q + bus.s_rdata;

    always_ff @(posedge clok or negedge resetm) begin
        if (!resetm) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.start_over) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (bus.start) state_d = SI_ADDR;
                SI_ADDR:  state_d = SI_WAIT;
                SI_WAIT:  state_d = SI_LATCH;
                SI_LATCH: state_d = SJ_ADDR;
                SJ_ADDR:  state_d = SJ_WAIT;
                SJ_WAIT:  state_d = SJ_LATCH;
                SJ_LATCH: state_d = WR_I;
                WR_I:     state_d = WR_J;
                WR_J:     state_d = F_ADDR;
                F_ADDR:   state_d = F_WAIT;
                F_WAIT:   state_d = F_LATCH;
                F_LATCH:  state_d = EMIT;
                EMIT:     state_d = WAIT_CMP;
                WAIT_CMP: if (ack_seen) state_d = (k_q == LAST_K) ? DONE : SI_ADDR;
                DONE:     state_d = DONE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Register loads happen on the edge that ends each state, so the S/ROM reads
    // land exactly two edges after their address and new_char shows during EMIT.
    always_comb begin
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        si_d       = si_q;
        sj_d       = sj_q;
        f_d        = f_q;
        enc_d      = enc_q;
        ack_pend_d = ack_pend_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wren_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        dec_addr_d = dec_addr_q;
        dec_wren_d = 1'b0;
        new_char_d = 1'b0;
        if (bus.start_over) begin
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            ack_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    i_d = '0;
                    j_d = '0;
                    k_d = '0;
                    if (bus.start) begin
                        i_d      = 8'd1;
                        s_addr_d = 8'd1;
                    end
                end
                SI_LATCH: begin
                    si_d     = bus.s_rdata;
                    j_d      = j_sum;
                    s_addr_d = j_sum;
                end
                SJ_LATCH: begin
                    sj_d      = bus.s_rdata;
                    s_addr_d  = i_q;
                    s_wdata_d = bus.s_rdata;
                    s_wren_d  = 1'b1;
                end
                WR_I: begin
                    s_addr_d  = j_q;
                    s_wdata_d = si_q;
                    s_wren_d  = 1'b1;
                end
                WR_J: begin
                    s_addr_d   = si_q + sj_q;
                    rom_addr_d = k_q[4:0];
                end
                F_LATCH: begin
                    f_d        = bus.s_rdata;
                    enc_d      = bus.rom_rdata;
                    dec_addr_d = k_q[4:0];
                    dec_wren_d = 1'b1;
                    new_char_d = 1'b1;
                end
                EMIT: ack_pend_d = bus.compared_char;
                WAIT_CMP: begin
                    if (ack_seen) begin
                        ack_pend_d = 1'b0;
                        k_d        = k_q + 6'd1;
                        if (k_q != LAST_K) begin
                            i_d      = i_q + 8'd1;
                            s_addr_d = i_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clok or negedge resetm) begin
        if (!resetm) begin
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            f_q        <= '0;
            enc_q      <= '0;
            ack_pend_q <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wren_q   <= 1'b0;
            rom_addr_q <= '0;
            dec_addr_q <= '0;
            dec_wren_q <= 1'b0;
            new_char_q <= 1'b0;
        end else begin
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            f_q        <= f_d;
            enc_q      <= enc_d;
            ack_pend_q <= ack_pend_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wren_q   <= s_wren_d;
            rom_addr_q <= rom_addr_d;
            dec_addr_q <= dec_addr_d;
            dec_wren_q <= dec_wren_d;
            new_char_q <= new_char_d;
        end
    end

    // Plaintext is formed from the latched keystream and ciphertext, so it holds across aborts.
    assign bus.char_out  = f_q ^ enc_q;
    assign bus.dec_wdata = f_q ^ enc_q;
    assign bus.dec_addr  = dec_addr_q;
    assign bus.dec_wren  = dec_wren_q;
    assign bus.new_char  = new_char_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.s_wren    = s_wren_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.k         = k_q;
    assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_rc4_decrypt_loop.sv
// Bench for rc4_decrypt_loop: memory models, reference RC4 scoreboard, table of
// whole-message runs plus hand sequences for abort, async reset and ignored starts.
module tb_rc4_decrypt_loop;
    localparam int MSG_LEN = 32;

    logic clok;
    logic resetm;
    initial clok = 1'b0;
    always #5 clok = ~clok;

    rc4_decrypt_loop_if bus();

    rc4_decrypt_loop #(.MSG_LEN(MSG_LEN)) dut (
        .clok   (clok),
        .resetm (resetm),
        .bus    (bus)
    );

    logic [7:0] smem [256];
    logic [7:0] s_init [256];
    logic [7:0] rom [32];
    logic [7:0] dec [32];
    logic       load_mem;
    logic [7:0] s_addr_r, s_rdata_r, rom_rdata_r;
    logic [4:0] rom_addr_r;

    // Synchronous memories: address registered, then data registered.
    always @(posedge clok) begin
        if (load_mem) begin
            for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
            for (int a = 0; a < 32; a++) dec[a] <= 8'h00;
        end else begin
            if (bus.s_wren) smem[bus.s_addr] <= bus.s_wdata;
            if (bus.dec_wren) dec[bus.dec_addr] <= bus.dec_wdata;
        end
        s_addr_r    <= bus.s_addr;
        s_rdata_r   <= smem[s_addr_r];
        rom_addr_r  <= bus.rom_addr;
        rom_rdata_r <= rom[rom_addr_r];
    end
    assign bus.s_rdata   = s_rdata_r;
    assign bus.rom_rdata = rom_rdata_r;

    int nc_cnt, dw_cnt, sw_cnt;
    always @(negedge clok) begin
        if (bus.new_char === 1'b1) nc_cnt <= nc_cnt + 1;
        if (bus.dec_wren === 1'b1) dw_cnt <= dw_cnt + 1;
        if (bus.s_wren === 1'b1) sw_cnt <= sw_cnt + 1;
    end

    typedef struct packed {
        logic [5:0] k;
        logic [7:0] ch;
    } exp_t;
    exp_t       exp_q[$];
    logic [7:0] exp_chars [32];

    int checks;
    int failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Independent RC4 PRGA over a snapshot of the S memory.
    task automatic build_expected();
        logic [7:0] rs [256];
        logic [7:0] ri, rj, t, fi;
        for (int a = 0; a < 256; a++) rs[a] = smem[a];
        ri = 8'd0;
        rj = 8'd0;
        exp_q.delete();
        for (int n = 0; n < MSG_LEN; n++) begin
            ri = ri + 8'd1;
            rj = rj + rs[ri];
            t = rs[ri];
            rs[ri] = rs[rj];
            rs[rj] = t;
            fi = rs[ri] + rs[rj];
            exp_chars[n] = rs[fi] ^ rom[n];
            exp_q.push_back({6'(n), exp_chars[n]});
        end
    endtask

    task automatic load_memories();
        load_mem = 1'b1;
        @(negedge clok);
        load_mem = 1'b0;
        @(negedge clok);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clok);
        bus.start = 1'b0;
    endtask

    task automatic abort_run();
        bus.start_over = 1'b1;
        @(negedge clok);
        bus.start_over = 1'b0;
        @(negedge clok);
        exp_q.delete();
    endtask

    task automatic wait_new_char(input int lead, output int lat, output bit ok);
        int cnt;
        cnt = lead;
        while (bus.new_char !== 1'b1 && cnt < 60) begin
            @(negedge clok);
            cnt++;
        end
        lat = cnt;
        ok = (bus.new_char === 1'b1);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL new_char_timeout: no strobe after %0d cycles, required one", cnt);
        end
    endtask

    task automatic get_char(input int lead, output bit ok);
        int   lat;
        exp_t e;
        wait_new_char(lead, lat, ok);
        if (!ok) return;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: strobe at k=%0d, required none", bus.k);
            ok = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        check("char_out", 32'(bus.char_out), 32'(e.ch));
        check("k", 32'(bus.k), 32'(e.k));
        check("dec_addr", 32'(bus.dec_addr), 32'(e.k[4:0]));
        check("dec_wdata", 32'(bus.dec_wdata), 32'(e.ch));
        check("dec_wren", 32'(bus.dec_wren), 32'd1);
        check("latency", 32'(lat), 32'd12);
        $display("char k=%0d char_out=0x%02h required=0x%02h latency=%0d",
                 bus.k, bus.char_out, e.ch, lat);
    endtask

    // style 0: ack in the cycle after new_char; style 1: ack in the same cycle.
    task automatic ack_char(input int style, output int lead);
        if (style == 0) begin
            @(negedge clok);
            check("new_char_pulse", 32'(bus.new_char), 32'd0);
            check("dec_wren_pulse", 32'(bus.dec_wren), 32'd0);
            bus.compared_char = 1'b1;
            @(negedge clok);
            bus.compared_char = 1'b0;
            lead = 1;
        end else begin
            bus.compared_char = 1'b1;
            @(negedge clok);
            bus.compared_char = 1'b0;
            check("new_char_pulse", 32'(bus.new_char), 32'd0);
            lead = 0;
        end
    endtask

    task automatic run_chars(input int n, input int style);
        int lead;
        bit ok;
        lead = 1;
        for (int idx = 0; idx < n; idx++) begin
            get_char(lead, ok);
            if (!ok) return;
            ack_char(style, lead);
        end
    endtask

    task automatic fill_s(input int mode);
        int b;
        logic [7:0] t;
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
        if (mode == 1) begin
            for (int a = 255; a > 0; a--) begin
                b = int'($urandom_range(a, 0));
                t = s_init[a];
                s_init[a] = s_init[b];
                s_init[b] = t;
            end
        end
    endtask

    task automatic fill_rom(input int mode);
        for (int a = 0; a < 32; a++) begin
            case (mode)
                1:       rom[a] = (a == 0) ? 8'h61 : 8'h00;
                2:       rom[a] = 8'($urandom_range(255, 0));
                3:       rom[a] = 8'hFF;
                default: rom[a] = 8'h00;
            endcase
        end
    endtask

    typedef struct {
        int s_mode;
        int rom_mode;
        int ack_style;
        int dec0_req;
    } case_t;
    case_t cases [5];

    initial begin
        int lead;
        int nc0, dw0, sw0;
        bit ok;

        checks = 0;
        failures = 0;
        resetm = 1'b0;
        load_mem = 1'b0;
        bus.start = 1'b0;
        bus.start_over = 1'b0;
        bus.compared_char = 1'b0;

        cases[0] = '{0, 0, 0, 8'h02};
        cases[1] = '{0, 1, 1, 8'h63};
        cases[2] = '{1, 2, 0, -1};
        cases[3] = '{1, 2, 1, -1};
        cases[4] = '{1, 3, 0, -1};

        repeat (2) @(negedge clok);
        check("rst_k", 32'(bus.k), 32'd0);
        check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("rst_char_out", 32'(bus.char_out), 32'd0);
        check("rst_strobes", {29'd0, bus.new_char, bus.dec_wren, bus.s_wren}, 32'd0);
        check("rst_addrs", {19'd0, bus.s_addr, bus.rom_addr}, 32'd0);
        resetm = 1'b1;
        @(negedge clok);

        // Whole-message runs.
        for (int c = 0; c < 5; c++) begin
            fill_s(cases[c].s_mode);
            fill_rom(cases[c].rom_mode);
            load_memories();
            build_expected();
            nc0 = nc_cnt;
            dw0 = dw_cnt;
            pulse_start();
            run_chars(MSG_LEN, cases[c].ack_style);
            repeat (2) @(negedge clok);
            check("done_k", 32'(bus.k), 32'd32);
            check("done_flag", 32'(bus.done), 32'd1);
            check("done_busy", 32'(bus.busy), 32'd0);
            check("new_char_count", 32'(nc_cnt - nc0), 32'd32);
            check("dec_wren_count", 32'(dw_cnt - dw0), 32'd32);
            pulse_start();
            repeat (15) @(negedge clok);
            check("done_start_k", 32'(bus.k), 32'd32);
            check("done_start_flag", 32'(bus.done), 32'd1);
            check("done_start_strobes", 32'(nc_cnt - nc0), 32'd32);
            for (int n = 0; n < MSG_LEN; n++) check("dec_mem", 32'(dec[n]), 32'(exp_chars[n]));
            if (cases[c].dec0_req >= 0) check("dec0_const", 32'(dec[0]), 32'(cases[c].dec0_req));
            $display("case %0d s_mode=%0d rom_mode=%0d ack_style=%0d done k=%0d",
                     c, cases[c].s_mode, cases[c].rom_mode, cases[c].ack_style, bus.k);
            abort_run();
            check("abort_done", {30'd0, bus.busy, bus.done}, 32'd0);
            check("abort_k", 32'(bus.k), 32'd0);
        end

        // Identity S: first two characters, swap result, start ignored in WAIT_CMP.
        fill_s(0);
        fill_rom(0);
        load_memories();
        build_expected();
        pulse_start();
        get_char(1, ok);
        check("id_char0", 32'(bus.char_out), 32'h02);
        @(negedge clok);
        nc0 = nc_cnt;
        bus.start = 1'b1;
        @(negedge clok);
        bus.start = 1'b0;
        repeat (3) @(negedge clok);
        check("waitcmp_start_k", 32'(bus.k), 32'd0);
        check("waitcmp_start_busy", 32'(bus.busy), 32'd1);
        check("waitcmp_start_strobe", 32'(nc_cnt - nc0), 32'd0);
        check("waitcmp_hold_char", 32'(bus.char_out), 32'h02);
        bus.compared_char = 1'b1;
        @(negedge clok);
        bus.compared_char = 1'b0;
        get_char(1, ok);
        check("id_char1", 32'(bus.char_out), 32'h05);
        check("swap_s2", 32'(smem[2]), 32'd3);
        check("swap_s3", 32'(smem[3]), 32'd2);
        $display("seq identity char1=0x%02h s2=%0d s3=%0d", bus.char_out, smem[2], smem[3]);
        abort_run();

        // Mismatch abort at k=5: ack then start_over held three cycles.
        fill_s(0);
        fill_rom(2);
        load_memories();
        build_expected();
        pulse_start();
        run_chars(5, 0);
        get_char(1, ok);
        @(negedge clok);
        bus.compared_char = 1'b1;
        @(negedge clok);
        bus.compared_char = 1'b0;
        bus.start_over = 1'b1;
        bus.start = 1'b1;
        sw0 = sw_cnt;
        nc0 = nc_cnt;
        repeat (3) @(negedge clok);
        check("abort_hold_busy", 32'(bus.busy), 32'd0);
        bus.start_over = 1'b0;
        bus.start = 1'b0;
        repeat (10) @(negedge clok);
        check("abort5_k", 32'(bus.k), 32'd0);
        check("abort5_busy", 32'(bus.busy), 32'd0);
        check("abort5_no_swren", 32'(sw_cnt - sw0), 32'd0);
        check("abort5_no_strobe", 32'(nc_cnt - nc0), 32'd0);
        $display("seq abort k=%0d busy=%0d s_wren_after=%0d", bus.k, bus.busy, sw_cnt - sw0);
        build_expected();
        pulse_start();
        run_chars(2, 1);
        abort_run();

        // Asynchronous reset asserted while the swap is writing S[i].
        fill_s(1);
        fill_rom(2);
        load_memories();
        build_expected();
        pulse_start();
        lead = 0;
        while (bus.s_wren !== 1'b1 && lead < 30) begin
            @(negedge clok);
            lead++;
        end
        check("wr_i_reached", 32'(bus.s_wren), 32'd1);
        #1 resetm = 1'b0;
        #1;
        check("arst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("arst_strobes", {29'd0, bus.new_char, bus.dec_wren, bus.s_wren}, 32'd0);
        check("arst_k_char", {18'd0, bus.k, bus.char_out}, 32'd0);
        check("arst_addr", 32'(bus.s_addr), 32'd0);
        $display("seq async_reset busy=%0d s_wren=%0d k=%0d", bus.busy, bus.s_wren, bus.k);
        @(negedge clok);
        resetm = 1'b1;
        @(negedge clok);
        build_expected();
        pulse_start();
        run_chars(3, 0);
        abort_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rc4_decrypt_loop.md
# rc4_decrypt_loop

Third RC4 stage ("loop 3") of the key-search datapath. After loops 1 and 2 build the S-box, this block runs the RC4 keystream generator against the 32-byte encrypted ROM. It XORs each keystream byte with the ciphertext, writes the plaintext to the decrypted RAM, and hands each character to the downstream character checker one at a time. The checker either acknowledges the character or orders a restart with the next key.

## Interface
Parameters:
- MSG_LEN, 32: number of message bytes; `k` counts 0..MSG_LEN.

Ports:
- clok, input, 1: system clock; all state updates on the rising edge.
- resetm, input, 1: asynchronous, active-low reset.
- start, input, 1: pulse from loop 2 (S-box ready). Sampled only in IDLE.
- start_over, input, 1: level from the checker. Aborts to IDLE from any state.
- compared_char, input, 1: one-cycle acknowledge from the checker; the current character has been judged.
- s_addr, output, 8: S memory address, registered.
- s_wdata, output, 8: S memory write data, registered.
- s_wren, output, 1: S memory write enable, registered.
- s_rdata, input, 8: S memory read data, valid 2 cycles after `s_addr` is registered.
- rom_addr, output, 5: encrypted ROM address; same read timing as S memory.
- rom_rdata, input, 8: encrypted byte.
- dec_addr, output, 5: decrypted RAM address.
- dec_wdata, output, 8: decrypted RAM write data.
- dec_wren, output, 1: decrypted RAM write enable.
- char_out, output, 8: plaintext byte; to checker `char_recieved`.
- new_char, output, 1: one-cycle strobe; `char_out` is valid.
- k, output, 6: current byte index; to checker `char_count`.
- busy, output, 1: high in every state except IDLE and DONE. Drives the S memory ownership mux.
- done, output, 1: high in DONE.

## Operation
- Reset:
  - All outputs go to 0.
  - Internal registers go to 0: i, j, k, si, sj, f, enc.
  - State goes to IDLE.
- IDLE:
  - i, j and k are cleared.
  - On `start` with `start_over`=0, go to SI_ADDR.
- Per-byte sequence, one cycle per state. All index arithmetic is 8-bit and wraps mod 256.
  - SI_ADDR: i <= i+1; s_addr <= i+1.
  - SI_WAIT.
  - SI_LATCH: si <= s_rdata; j <= j + s_rdata.
  - SJ_ADDR: s_addr <= j, using the updated j.
  - SJ_WAIT.
  - SJ_LATCH: sj <= s_rdata.
  - WR_I: s_addr <= i; s_wdata <= sj; s_wren <= 1.
  - WR_J: s_addr <= j; s_wdata <= si; s_wren <= 1.
  - F_ADDR: s_wren <= 0; s_addr <= si+sj; rom_addr <= k[4:0].
  - F_WAIT.
  - F_LATCH: f <= s_rdata; enc <= rom_rdata.
  - EMIT:
    - char_out <= f ^ enc; dec_addr <= k[4:0]; dec_wdata <= f ^ enc.
    - dec_wren <= 1 and new_char <= 1, each for this one cycle.
    - Go to WAIT_CMP.
  - WAIT_CMP:
    - Hold `char_out` and `k`.
    - On `compared_char`: k <= k+1. Then go to DONE if k was MSG_LEN-1; otherwise go to SI_ADDR.
- DONE:
  - `done` = 1 and `k` = MSG_LEN, so the checker sees `char_count` ≥ 32 and finishes.
  - Stays in DONE until `start_over` or reset.
- `start_over`:
  - Highest priority, from every state.
  - Next edge: state to IDLE; i, j, k to 0.
  - s_wren, dec_wren, new_char, done and busy go to 0.
  - `char_out` keeps its last value.
  - While `start_over` stays high, `start` is ignored; it is accepted again only after `start_over` drops.
- A mismatch abort arrives as `compared_char` followed one cycle later by `start_over`. The block may advance `k` and enter SI_ADDR first; the abort then returns it to IDLE.
- `start` in any state other than IDLE is ignored.

## Timing
- From the edge leaving IDLE (or leaving WAIT_CMP), `new_char` is high in the 12th following cycle.
- `new_char` and `dec_wren` are single-cycle pulses, never held.
- The two S writes of the swap happen in consecutive cycles, i then j. If i == j, the second write rewrites the same value and the result is correct.
- No S read is issued in the cycle immediately after a write to that address. The swap-then-read order in F_ADDR guarantees this.
- `compared_char` is ignored outside WAIT_CMP.
- A `compared_char` that arrives on the same edge EMIT completes is not missed: WAIT_CMP is entered and the acknowledge is honoured there.

## Test plan
- Identity S (s[x]=x), ROM all 0x00, `start` pulse, checker model acks 1 cycle after each `new_char`:
  - char 0 = 0x02 (i=1, j=1), written at dec[0].
  - char 1 = 0x05 (i=2, j=3), after which s[2]=3 and s[3]=2.
- Same setup but ROM[0]=0x61 -> char_out=0x63, dec[0]=0x63.
- Ack all 32 characters:
  - k steps 0..31, then k=32.
  - done=1, busy=0.
  - Exactly 32 `new_char` pulses and 32 `dec_wren` pulses.
- `compared_char` at k=5, then `start_over` held 3 cycles:
  - Block returns to IDLE with k=0 and no further `s_wren`.
  - A new `start` restarts at k=0.
- Assert `resetm`=0 mid-sequence in WR_I: all outputs 0 and state IDLE immediately (async); `start` after release resumes normally.
- `start` pulsed during WAIT_CMP and during DONE: no effect, and `k` is unchanged.
